// File: rtl/bar_processor.sv
// rtl/bar_processor.sv - FFT bins to peak-held, clipped VGA bar heights
module bar_processor #(
    parameter int N_BINS      = 16,
    parameter int IN_W        = 36,
    parameter int BAR_W       = 18,
    parameter int SCALE_SHIFT = 0,
    parameter int BAR_MAX     = 480,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_BINS*IN_W-1:0]    freqs,
    output logic [N_BINS*BAR_W-1:0]   bars,
    output logic                      busy,
    output logic                      done
);

    localparam int HALF_W = IN_W / 2;
    localparam int IDX_W  = $clog2(N_BINS);

    typedef enum logic [1:0] {IDLE, CAPTURE, PROC, COMMIT} state_t;

    state_t                     state_q, state_d;
    logic [N_BINS*IN_W-1:0]     snap;
    logic [N_BINS*BAR_W-1:0]    work;
    logic [N_BINS*BAR_W-1:0]    commit_vec;
    logic [IDX_W-1:0]           idx;
    logic                       last;

    logic [IN_W-1:0]            cur;
    logic [HALF_W-2:0]          a, b, mx, mn;
    logic [HALF_W-1:0]          mag, scaled;
    logic [BAR_W-1:0]           clipped, prev, step, decayed, result;

    // |-2^(W-1)| does not fit in W-1 bits, so it saturates to the largest magnitude
    function automatic logic [HALF_W-2:0] abs_sat(input logic [HALF_W-1:0] v);
        if (!v[HALF_W-1])
            return v[HALF_W-2:0];
        else if (v[HALF_W-2:0] == '0)
            return '1;
        else
            return ~v[HALF_W-2:0] + (HALF_W-1)'(1);
    endfunction

    assign last = (idx == IDX_W'(N_BINS - 1));

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                busy    = 1'b1;
                state_d = PROC;
            end
            PROC: begin
                busy = 1'b1;
                if (last)
                    state_d = COMMIT;
            end
            COMMIT: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Alpha-max-beta-min magnitude, then scale/clip, then peak-hold against the displayed bar
    always_comb begin
        cur = snap[idx*IN_W +: IN_W];
        a   = abs_sat(cur[IN_W-1:HALF_W]);
        b   = abs_sat(cur[HALF_W-1:0]);
        mx  = (a > b) ? a : b;
        mn  = (a > b) ? b : a;
        mag = {1'b0, mx} + HALF_W'(mn >> 1);
        scaled = mag >> SCALE_SHIFT;
        if (scaled > HALF_W'(BAR_MAX))
            clipped = BAR_W'(BAR_MAX);
        else
            clipped = BAR_W'(scaled);

        prev = bars[idx*BAR_W +: BAR_W];
        step = prev >> DECAY_SHIFT;
        if (step == '0)
            step = BAR_W'(1);
        decayed = (prev == '0) ? '0 : prev - step;
        result  = (clipped > decayed) ? clipped : decayed;
    end

    // The last bin is merged here so the full set lands in bars on entry to COMMIT
    always_comb begin
        commit_vec = work;
        commit_vec[(N_BINS-1)*BAR_W +: BAR_W] = result;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap <= '0;
            work <= '0;
            bars <= '0;
            idx  <= '0;
        end else if (state_q == CAPTURE) begin
            snap <= freqs;
            idx  <= '0;
        end else if (state_q == PROC) begin
            work[idx*BAR_W +: BAR_W] <= result;
            idx <= idx + IDX_W'(1);
            if (last)
                bars <= commit_vec;
        end
    end

endmodule

// File: tb/tb_bar_processor.sv
// tb/tb_bar_processor.sv - directed table-driven bench for bar_processor
module tb_bar_processor;

    localparam int NB = 16;
    localparam int IW = 36;
    localparam int BWD = 18;
    localparam int FW = NB * IW;
    localparam int BW = NB * BWD;
    localparam logic [31:0] BUSY_FULL = 32'h0003_FFFE;

    logic          clk;
    logic          rst;
    logic          start;
    logic [FW-1:0] freqs;
    logic [BW-1:0] bars;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    bar_processor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .freqs (freqs),
        .bars  (bars),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [FW-1:0] f;
        logic [BW-1:0] e;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [FW-1:0] fbin(logic [FW-1:0] v, int k, int re, int im);
        logic [FW-1:0] r;
        r = v;
        r[k*IW +: IW] = {18'(re), 18'(im)};
        return r;
    endfunction

    function automatic logic [BW-1:0] bset(logic [BW-1:0] v, int k, int h);
        logic [BW-1:0] r;
        r = v;
        r[k*BWD +: BWD] = 18'(h);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Pulse start at edge 0 and observe cycles 1..24; optional mid-frame events by cycle number
    task automatic frame(input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                         input int chg_c, input int start2_c, input int rst_c,
                         output int done_c, output int done_n, output int bar_chg_c,
                         output logic [31:0] busy_m);
        logic [BW-1:0] b0;
        done_c = -1;
        done_n = 0;
        bar_chg_c = -1;
        busy_m = '0;
        b0 = bars;
        freqs = f0;
        start = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (busy) busy_m[c] = 1'b1;
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (bars !== b0 && bar_chg_c < 0) bar_chg_c = c;
            freqs = (chg_c >= 0 && c >= chg_c) ? f1 : f0;
            start = (c == start2_c);
            rst   = (c != rst_c);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst = 1'b1;
    endtask

    int dc, dn, bc, ndone, nbusy;
    logic [31:0] bm;
    logic [FW-1:0] fz, fa, fb;
    logic [BW-1:0] e;

    initial begin
        fz = '0;

        tbl[0].f = fbin(fz, 3, 200, -100);
        tbl[0].e = bset('0, 3, 250);
        tbl[1].f = fz;  tbl[1].e = bset('0, 3, 219);
        tbl[2].f = fz;  tbl[2].e = bset('0, 3, 192);
        tbl[3].f = fz;  tbl[3].e = bset('0, 3, 168);
        tbl[4].f = fbin(fbin(fz, 0, -131072, -131072), 5, 5, 0);
        tbl[4].e = bset(bset(bset('0, 0, 480), 3, 147), 5, 5);
        tbl[5].f = fz;
        tbl[5].e = bset(bset(bset('0, 0, 420), 3, 129), 5, 4);
        tbl[6].f = fz;
        tbl[6].e = bset(bset(bset('0, 0, 368), 3, 113), 5, 3);
        tbl[7].f = fbin(fz, 3, 300, 0);
        tbl[7].e = bset(bset(bset('0, 0, 322), 3, 300), 5, 2);
        tbl[8].f = fbin(fbin(fbin(fz, 7, -50, 120), 15, 1, 1), 12, 0, -131072);
        tbl[8].e = bset(bset(bset(bset(bset(bset('0, 0, 282), 3, 263), 5, 1), 7, 145), 12, 480), 15, 1);
        tbl[9].f = fz;
        tbl[9].e = bset(bset(bset(bset('0, 0, 247), 3, 231), 7, 127), 12, 420);

        // Reset held with start high, then no activity afterwards
        rst = 1'b0;
        start = 1'b1;
        freqs = fbin(fz, 0, -131072, -131072);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_bars", bars, '0);
        chk("reset_busy", BW'(busy), '0);
        chk("reset_done", BW'(done), '0);
        rst = 1'b1;
        start = 1'b0;
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("post_reset_done_cnt", BW'(ndone), '0);
        chk("post_reset_busy_cnt", BW'(nbusy), '0);

        for (int i = 0; i < 10; i++) begin
            frame(tbl[i].f, tbl[i].f, -1, -1, -1, dc, dn, bc, bm);
            chk($sformatf("row%0d_bars", i), bars, tbl[i].e);
            chk($sformatf("row%0d_done_cycle", i), BW'(dc), BW'(18));
            chk($sformatf("row%0d_done_cnt", i), BW'(dn), BW'(1));
            chk($sformatf("row%0d_busy_mask", i), BW'(bm), BW'(BUSY_FULL));
            if (i == 0)
                chk("row0_bars_first_change", BW'(bc), BW'(18));
        end

        // freqs change in cycle 3, extra start in cycle 5 and in the COMMIT cycle
        fa = fbin(fz, 1, 64, 0);
        fb = fbin(fz, 1, 400, 0);
        frame(fa, fb, 3, 5, -1, dc, dn, bc, bm);
        e = bset(bset(bset(bset(bset('0, 0, 217), 1, 64), 3, 203), 7, 112), 12, 368);
        chk("hs_bars", bars, e);
        chk("hs_done_cycle", BW'(dc), BW'(18));
        chk("hs_done_cnt", BW'(dn), BW'(1));
        frame(fz, fz, -1, 18, -1, dc, dn, bc, bm);
        chk("hs_commit_start_busy", BW'(bm), BW'(BUSY_FULL));
        chk("hs_commit_start_done_cnt", BW'(dn), BW'(1));

        // Reset during PROC aborts the frame
        frame(fbin(fz, 2, 10, 0), fz, -1, -1, 10, dc, dn, bc, bm);
        chk("midrst_done_cnt", BW'(dn), '0);
        chk("midrst_busy_mask", BW'(bm), BW'(32'h0000_07FE));
        chk("midrst_bars", bars, '0);
        chk("midrst_busy_after", BW'(busy), '0);

        frame(fbin(fz, 3, 200, -100), fz, -1, -1, -1, dc, dn, bc, bm);
        chk("after_rst_bars", bars, bset('0, 3, 250));
        chk("after_rst_done_cycle", BW'(dc), BW'(18));
        chk("after_rst_done_cnt", BW'(dn), BW'(1));
        chk("after_rst_first_change", BW'(bc), BW'(18));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
